// File: rtl/s2_kes_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : s2_kes_sched_if
//  Description : Bundle of requester, engine and result-stage signals for the
//                shared key-equation-solver scheduler. The master modport is
//                the scheduler's view; slave is the environment's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface s2_kes_sched_if;
    // Syndrome requesters
    logic        req0_valid;
    logic [31:0] req0_syn;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_syn;
    logic        req1_ready;
    // Key-equation engine
    logic        kes_ena;
    logic [31:0] kes_syn;
    logic        kes_done;
    logic [23:0] kes_lambda;
    logic [15:0] kes_omega;
    // Result stage
    logic        out_valid;
    logic        out_ready;
    logic        out_tag;
    logic [23:0] out_lambda;
    logic [15:0] out_omega;
    logic        out_err;
    logic        busy;

    modport master (
        input  req0_valid, req0_syn, req1_valid, req1_syn,
        input  kes_done, kes_lambda, kes_omega, out_ready,
        output req0_ready, req1_ready, kes_ena, kes_syn,
        output out_valid, out_tag, out_lambda, out_omega, out_err, busy
    );

    modport slave (
        output req0_valid, req0_syn, req1_valid, req1_syn,
        output kes_done, kes_lambda, kes_omega, out_ready,
        input  req0_ready, req1_ready, kes_ena, kes_syn,
        input  out_valid, out_tag, out_lambda, out_omega, out_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/s2_kes_sched.sv
`default_nettype none
// ============================================================================
//  Module      : s2_kes_sched
//  Description : Round-robin scheduler sharing one RIBM key-equation engine
//                between two syndrome requesters. Zero syndrome sets bypass
//                the engine; a stuck engine is aborted after TIMEOUT WAIT
//                cycles and reported with out_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module s2_kes_sched #(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    s2_kes_sched_if.master     bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_OUT    = 2'd3;

    // Last WAIT timer value before the abort fires (15 WAIT cycles in total)
    localparam logic [TMR_W-1:0] c_TMO_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_rr_ptr;
    logic [31:0]      r_syn;
    logic             r_tag;
    logic [23:0]      r_lambda;
    logic [15:0]      r_omega;
    logic             r_err;
    logic             r_kes_ena;
    logic [TMR_W-1:0] r_tmr;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [31:0]      w_syn;

    // Grant: a lone valid wins; with both valid, rr_ptr picks the requester
    always_comb begin
        w_idle   = (r_state == c_IDLE);
        w_gnt0   = w_idle && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
        w_gnt1   = w_idle && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
        w_accept = w_gnt0 || w_gnt1;
        w_syn    = w_gnt1 ? bus.req1_syn : bus.req0_syn;
    end

    // Control FSM, capture registers and WAIT timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_rr_ptr  <= 1'b0;
            r_syn     <= '0;
            r_tag     <= 1'b0;
            r_lambda  <= '0;
            r_omega   <= '0;
            r_err     <= 1'b0;
            r_kes_ena <= 1'b0;
            r_tmr     <= '0;
        end else begin
            r_kes_ena <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_syn    <= w_syn;
                        r_tag    <= w_gnt1;
                        r_rr_ptr <= ~w_gnt1;
                        if (w_syn == 32'h0) begin
                            // No errors: locator is the constant 1, nothing to solve
                            r_state  <= c_OUT;
                            r_lambda <= 24'h000001;
                            r_omega  <= '0;
                            r_err    <= 1'b0;
                        end else begin
                            r_state   <= c_LAUNCH;
                            r_kes_ena <= 1'b1;
                        end
                    end
                end
                c_LAUNCH: begin
                    r_tmr   <= '0;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_tmr <= r_tmr + 1'b1;
                    // Engine completion takes priority over a coincident abort
                    if (bus.kes_done) begin
                        r_lambda <= bus.kes_lambda;
                        r_omega  <= bus.kes_omega;
                        r_err    <= 1'b0;
                        r_state  <= c_OUT;
                    end else if (r_tmr == c_TMO_LAST) begin
                        r_lambda <= '0;
                        r_omega  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= c_OUT;
                    end
                end
                c_OUT: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outputs come straight from registers except the grant handshake
    always_comb begin
        bus.req0_ready = w_gnt0;
        bus.req1_ready = w_gnt1;
        bus.kes_ena    = r_kes_ena;
        bus.kes_syn    = r_syn;
        bus.out_valid  = (r_state == c_OUT);
        bus.out_tag    = r_tag;
        bus.out_lambda = r_lambda;
        bus.out_omega  = r_omega;
        bus.out_err    = r_err;
        bus.busy       = !w_idle;
    end

endmodule
`default_nettype wire

// File: tb/tb_s2_kes_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s2_kes_sched
//  Description : Self-checking bench for s2_kes_sched. A transaction-timeline
//                model predicts grants, launch pulse, result timing and
//                contents every cycle; directed tests add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s2_kes_sched;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1 << 30;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    s2_kes_sched_if bus ();

    s2_kes_sched #(.TIMEOUT(TIMEOUT), .TMR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Engine behaviour: lambda/omega are a fixed function of the syndromes
    function automatic logic [39:0] eng_fn(input logic [31:0] s);
        return {s[23:0] ^ 24'hA5A5A5, s[31:16] ^ s[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- engine model ----------------
    int          eng_delay = 5;      // cycles from kes_ena to kes_done, <0 = never
    int          eng_at = -1;
    logic [31:0] eng_syn = '0;
    int          stray_cnt = 0;
    int          stray_seen = 0;

    always @(negedge clk) begin
        if (bus.kes_ena === 1'b1 && eng_delay >= 0) begin
            eng_at  <= cyc + eng_delay;
            eng_syn <= bus.kes_syn;
        end
    end

    initial begin
        bus.kes_done   = 1'b0;
        bus.kes_lambda = '0;
        bus.kes_omega  = '0;
        forever begin
            @(posedge clk); #1;
            bus.kes_done   = 1'b0;
            bus.kes_lambda = '0;
            bus.kes_omega  = '0;
            if (stray_cnt != stray_seen) begin
                stray_seen     = stray_cnt;
                bus.kes_done   = 1'b1;
                bus.kes_lambda = 24'hBAD0BA;
                bus.kes_omega  = 16'hDEAD;
            end else if (cyc == eng_at) begin
                bus.kes_done = 1'b1;
                {bus.kes_lambda, bus.kes_omega} = eng_fn(eng_syn);
            end
        end
    end

    // ---------------- timeline model + per-cycle compare ----------------
    bit          m_busy, m_rr, m_tag, m_zero, m_err, m_acc_now, m_g1;
    int          m_acc, m_ready;
    logic [31:0] m_syn;
    logic [23:0] m_lam;
    logic [15:0] m_om;
    logic        e_r0, e_r1, e_ena, e_valid;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.kes_ena, bus.out_valid,
                             bus.busy, bus.out_tag, bus.out_err}, 0);
            chk("rst_data", {bus.out_lambda, bus.out_omega}, 0);
            chk("rst_syn", bus.kes_syn, 0);
            m_busy = 0; m_rr = 0; m_ready = NEVER; m_acc = -100;
        end else begin
            e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || !m_rr);
            e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid ||  m_rr);
            e_ena   = m_busy && !m_zero && (cyc == m_acc + 1);
            e_valid = m_busy && (cyc >= m_ready);
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("busy", bus.busy, m_busy);
            chk("kes_ena", bus.kes_ena, e_ena);
            chk("out_valid", bus.out_valid, e_valid);
            if (m_busy && !m_zero && cyc > m_acc && cyc < m_ready)
                chk("kes_syn", bus.kes_syn, m_syn);
            if (e_valid) begin
                chk("out_tag", bus.out_tag, m_tag);
                chk("out_lambda", bus.out_lambda, m_lam);
                chk("out_omega", bus.out_omega, m_om);
                chk("out_err", bus.out_err, m_err);
            end
            // advance the timeline
            m_acc_now = !m_busy && (e_r0 || e_r1);
            if (m_busy && !m_zero && bus.kes_done && cyc >= m_acc + 2 && cyc < m_ready) begin
                m_ready = cyc + 1;
                {m_lam, m_om} = eng_fn(m_syn);
                m_err = 0;
            end
            if (m_busy && cyc >= m_ready && bus.out_ready)
                m_busy = 0;
            if (m_acc_now) begin
                m_g1   = e_r1;
                m_busy = 1;
                m_acc  = cyc;
                m_tag  = m_g1;
                m_rr   = !m_g1;
                m_syn  = m_g1 ? bus.req1_syn : bus.req0_syn;
                m_zero = (m_syn == 0);
                if (m_zero) begin
                    m_ready = cyc + 1; m_lam = 24'h000001; m_om = 0; m_err = 0;
                end else begin
                    // abort result unless the engine finishes within the WAIT window
                    m_ready = cyc + 2 + TIMEOUT; m_lam = 0; m_om = 0; m_err = 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int id, input logic [31:0] syn, output int acc);
        acc = -1;
        if (id == 0) begin bus.req0_valid = 1'b1; bus.req0_syn = syn; end
        else         begin bus.req1_valid = 1'b1; bus.req1_syn = syn; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_chk++; n_err++;
            $display("FAIL send_accept: req%0d never granted, want grant within 60 cycles", id);
        end
        step();
        if (id == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin c = cyc; break; end
        end
        if (c < 0) begin
            n_chk++; n_err++;
            $display("FAIL wait_out: out_valid absent, want it within 40 cycles");
        end
    endtask

    int acc, c;
    int tags[4];

    initial begin
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_syn = 0;
        bus.req1_valid = 0; bus.req1_syn = 0;
        bus.out_ready  = 1;
        step(3);
        rst = 1'b0;
        step(2);

        // 1: engine path, nominal latency
        send(0, 32'h00000F0E, acc);
        wait_out(c);
        chk("t1_latency", c - acc, 7);
        chk("t1_tag", bus.out_tag, 0);
        chk("t1_lambda", bus.out_lambda, 24'hA5AAAB);
        chk("t1_omega", bus.out_omega, 16'h0F0E);
        step(2);

        // 2: all-zero syndromes bypass the engine
        send(0, 32'h0, acc);
        wait_out(c);
        chk("t2_latency", c - acc, 1);
        chk("t2_lambda", bus.out_lambda, 24'h000001);
        chk("t2_omega_err", {bus.out_omega, bus.out_err}, 0);
        step(2);

        // lone req1 via engine: tag 1, leaves rr favouring req0
        send(1, 32'hDEADBEEF, acc);
        wait_out(c);
        chk("r1_tag", bus.out_tag, 1);
        chk("r1_lambda", bus.out_lambda, 24'h081B4A);
        chk("r1_omega", bus.out_omega, 16'h6042);
        step(2);

        // 3: both valid for four grants
        bus.req0_syn = 32'h11223344; bus.req1_syn = 32'h0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            wait_out(c);
            tags[i] = bus.out_tag;
        end
        step();
        bus.req0_valid = 0; bus.req1_valid = 0;
        chk("t3_order", {tags[0][0], tags[1][0], tags[2][0], tags[3][0]}, 4'b0101);
        step(2);

        // 4: engine never finishes -> abort, then normal service
        eng_delay = -1;
        send(0, 32'h00000001, acc);
        wait_out(c);
        chk("t4_latency", c - acc, TIMEOUT + 2);
        chk("t4_err", bus.out_err, 1);
        chk("t4_data", {bus.out_lambda, bus.out_omega}, 0);
        step(2);
        eng_delay = 5;
        send(1, 32'hDEADBEEF, acc);
        wait_out(c);
        chk("t4b_err", bus.out_err, 0);
        chk("t4b_lambda", bus.out_lambda, 24'h081B4A);
        step(2);

        // done in the last WAIT cycle wins over the abort
        eng_delay = TIMEOUT;
        send(0, 32'h00000F0E, acc);
        wait_out(c);
        chk("tc_latency", c - acc, TIMEOUT + 2);
        chk("tc_err", bus.out_err, 0);
        chk("tc_lambda", bus.out_lambda, 24'hA5AAAB);
        step(2);
        eng_delay = 5;

        // 5: back-pressure in OUT, stray done, pending requester
        bus.out_ready = 0;
        send(0, 32'h01020304, acc);
        wait_out(c);
        step();
        bus.req1_syn = 32'h00000F0E; bus.req1_valid = 1;
        step(4);
        stray_cnt++;
        step(6);
        @(negedge clk);
        chk("t5_held", bus.out_valid, 1);
        chk("t5_lambda", bus.out_lambda, 24'hA7A6A1);
        chk("t5_omega", bus.out_omega, 16'h0206);
        chk("t5_ready1", bus.req1_ready, 0);
        step();
        bus.req1_valid = 0;
        bus.out_ready = 1;
        step(3);

        // 6: reset while the engine is running; late done must be ignored
        send(0, 32'h00AA0055, acc);
        step(2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid_busy", {bus.out_valid, bus.busy, bus.kes_ena}, 0);
        step();
        rst = 1'b0;
        step(4);
        send(1, 32'h00000F0E, acc);
        wait_out(c);
        chk("t6_latency", c - acc, 7);
        chk("t6_tag", bus.out_tag, 1);
        chk("t6_lambda", bus.out_lambda, 24'hA5AAAB);
        step(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
